// File: rtl/csr_intr_unit_if.sv
// rtl/csr_intr_unit_if.sv - control-unit side bus of csr_intr_unit
interface csr_intr_unit_if;
  logic        intr_in;
  logic        instr_boundary;
  logic [31:0] pc;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic        mret_exec;
  logic        int_taken;
  logic [31:0] csr_rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  modport master (
    output intr_in, instr_boundary, pc, csr_we, csr_addr, csr_wd, mret_exec,
    input  int_taken, csr_rd, mtvec, mepc
  );

  modport slave (
    input  intr_in, instr_boundary, pc, csr_we, csr_addr, csr_wd, mret_exec,
    output int_taken, csr_rd, mtvec, mepc
  );
endinterface

// File: rtl/csr_intr_unit.sv
// rtl/csr_intr_unit.sv - machine-mode interrupt unit with mstatus/mtvec/mepc CSRs
// Optional mcause CSR (0x342) is built when CSR_INTR_MCAUSE_EN is defined.
module csr_intr_unit (
  input  logic           clk,
  input  logic           rst,
  csr_intr_unit_if.slave bus
);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, TAKE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sync1, r_sync2, r_sync_d;
  logic        r_pending;
  logic        r_int_taken;
  logic        r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mepc;
  logic [31:0] w_mcause;
  logic        w_rise;
  logic        w_take;
  logic        w_mret;
  logic        w_we;
  logic        w_we_mstatus, w_we_mtvec, w_we_mepc, w_we_mcause;

  // intr_in is asynchronous; r_sync_d only delays the synchronized level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= bus.intr_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_int_taken <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_int_taken <= (w_next_state == TAKE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_next_state = PEND;
      PEND:    if (bus.instr_boundary && r_mie) w_next_state = TAKE;
      TAKE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Take wins over mret, which wins over a CSR write touching the same field
  always_comb begin
    w_take       = 1'b0;
    w_mret       = 1'b0;
    w_we         = 1'b0;
    w_we_mstatus = 1'b0;
    w_we_mtvec   = 1'b0;
    w_we_mepc    = 1'b0;
    w_we_mcause  = 1'b0;
    w_take       = (r_state == PEND) && (w_next_state == TAKE);
    w_mret       = bus.mret_exec && !r_int_taken && !w_take;
    w_we         = bus.csr_we && !r_int_taken;
    w_we_mstatus = w_we && (bus.csr_addr == ADDR_MSTATUS) && !w_take && !bus.mret_exec;
    w_we_mtvec   = w_we && (bus.csr_addr == ADDR_MTVEC);
    w_we_mepc    = w_we && (bus.csr_addr == ADDR_MEPC) && !w_take;
    w_we_mcause  = w_we && (bus.csr_addr == ADDR_MCAUSE) && !w_take;
  end

  // Edges seen while a request is pending or being taken merge into it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_pending <= 1'b0;
    end else if (w_rise && (r_state == IDLE)) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (w_take) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_we_mstatus) begin
      r_mie  <= bus.csr_wd[3];
      r_mpie <= bus.csr_wd[7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtvec <= 32'h0;
    end else if (w_we_mtvec) begin
      r_mtvec <= bus.csr_wd & ~32'h3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mepc <= 32'h0;
    end else if (w_take) begin
      r_mepc <= bus.pc & ~32'h3;
    end else if (w_we_mepc) begin
      r_mepc <= bus.csr_wd & ~32'h3;
    end
  end

`ifdef CSR_INTR_MCAUSE_EN
  localparam logic [31:0] MCAUSE_EXT_INTR = 32'h8000_000B;
  logic [31:0] r_mcause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcause <= 32'h0;
    end else if (w_take) begin
      r_mcause <= MCAUSE_EXT_INTR;
    end else if (w_we_mcause) begin
      r_mcause <= bus.csr_wd;
    end
  end

  assign w_mcause = r_mcause;
`else
  assign w_mcause = (w_we_mcause && r_pending) ? 32'h0 : 32'h0;
`endif

  // Read data is the pre-write value, giving csrrw swap semantics
  always_comb begin
    bus.csr_rd = 32'h0;
    case (bus.csr_addr)
      ADDR_MSTATUS: bus.csr_rd = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
      ADDR_MTVEC:   bus.csr_rd = r_mtvec;
      ADDR_MEPC:    bus.csr_rd = r_mepc;
      ADDR_MCAUSE:  bus.csr_rd = w_mcause;
      default:      bus.csr_rd = 32'h0;
    endcase
  end

  assign bus.int_taken = r_int_taken;
  assign bus.mtvec     = r_mtvec;
  assign bus.mepc      = r_mepc;
endmodule

// File: doc/csr_intr_unit.md
CSR_INTR_UNIT -- requirements
Module: csr_intr_unit

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  sole clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  intr_in  in  1  external interrupt request, asynchronous, level.
  instr_boundary  in  1  one-cycle pulse from the CU FSM when an instruction retires; the only point where an interrupt is taken.
  pc  in  32  PC of the next instruction to execute, valid while instr_boundary=1.
  csr_we  in  1  csrrw write strobe.
  csr_addr  in  12  CSR address (instruction bits 31:20).
  csr_wd  in  32  csrrw write data (rs1).
  mret_exec  in  1  one-cycle pulse when mret executes.
  int_taken  out  1  interrupt redirect to the decoder (PC source 4).
  csr_rd  out  32  read data for csr_addr (rfile write source 1).
  mtvec  out  32  trap vector, PC-mux input.
  mepc  out  32  saved PC, PC-mux input for mret (source 5).

Function
REQ-002 intr_in SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL set the pending flag 3 cycles after intr_in rises.
REQ-003 The FSM SHALL have states IDLE, PEND, TAKE: IDLE->PEND when pending sets; PEND->TAKE on the cycle instr_boundary=1 and mstatus.MIE=1; TAKE->IDLE unconditionally after one cycle.
REQ-004 int_taken SHALL be a registered Moore output, 1 only in TAKE, exactly one cycle per accepted interrupt.
REQ-005 On the PEND->TAKE transition the block SHALL load mepc<=pc, MPIE<=MIE, MIE<=0 and clear pending.
REQ-006 In PEND with MIE=0 the request SHALL stay pending indefinitely and be taken at the first boundary after MIE becomes 1.
REQ-007 Further intr_in edges while pending or in TAKE SHALL be merged into the single outstanding request (no counting).
REQ-008 On mret_exec=1 the block SHALL load MIE<=MPIE, MPIE<=1.
REQ-009 CSR map: mstatus 0x300 (bit 3 MIE, bit 7 MPIE, other bits read 0, write-ignored), mtvec 0x305 (32 bits, bits 1:0 forced 0), mepc 0x341 (32 bits, bits 1:0 forced 0).
REQ-010 csr_rd SHALL be combinational from csr_addr and return the pre-write value in the cycle of csr_we (csrrw swap semantics); unmapped addresses SHALL read 0 and ignore writes.
REQ-011 csr_we writes SHALL update the addressed CSR at the next rising edge.
REQ-012 Simultaneous events priority: interrupt take > mret_exec > csr_we, for any field touched by more than one; a csr_we to mstatus concurrent with mret_exec SHALL be dropped.
REQ-013 csr_we and mret_exec SHALL be ignored in the cycle int_taken=1.
REQ-014 mtvec and mepc outputs SHALL reflect the registered CSR values with zero added latency.

Reset
REQ-015 rst=1 at a rising edge SHALL clear the synchronizer, pending flag, FSM (IDLE), int_taken, MIE, MPIE, mtvec and mepc to 0.
REQ-016 rst asserted in PEND or TAKE SHALL abort the interrupt; no int_taken pulse is produced after rst.

Configuration
REQ-017 Macro CSR_INTR_MCAUSE_EN: when defined, CSR 0x342 (mcause) SHALL exist, be loaded with 0x8000000B on each take, be writable by csrrw and reset to 0; when undefined, 0x342 SHALL read 0 and ignore writes.

Verification
REQ-018 rst, write mtvec=0x00000104, mstatus=0x8, raise intr_in, pulse instr_boundary with pc=0x200 -> one int_taken pulse, mepc=0x200, csr_rd@0x300=0x80.
REQ-019 MIE=0, raise intr_in, 5 boundary pulses -> no int_taken; write mstatus=0x8, next boundary -> one int_taken.
REQ-020 After a take, pulse mret_exec -> csr_rd@0x300=0x88, mepc unchanged at 0x200.
REQ-021 csr_we to 0x305 with csr_wd=0x0000ABCF -> csr_rd shows old value that cycle, 0x0000ABCC next cycle; write to 0x7C0 -> reads 0.
REQ-022 rst asserted in cycle of TAKE entry -> int_taken 0 thereafter, pending 0; with CSR_INTR_MCAUSE_EN, a prior take reads mcause=0x8000000B, 0 after reset.
